// File: rtl/uart_pkg.sv
// Shared UART constants used by the receive path.
package uart_pkg;

  // Oversample ticks per bit used by the receiver unless overridden.
  localparam int UART_OVS_DEFAULT = 16;

  // Level of an idle serial line; also the value SAMPLE_BIT holds after reset.
  localparam logic UART_IDLE_LVL = 1'b1;

endpackage

// File: rtl/rx_sample_timer_if.sv
// Bundle between the RX framing FSM (master) and the sample timer (slave).
// The FSM drives the tick, gate, realign and line inputs; the timer returns
// the strobes, the sampled bit and the current phase.
interface rx_sample_timer_if import uart_pkg::*; #(
  parameter int OVS   = UART_OVS_DEFAULT,
  parameter int CNT_W = $clog2(OVS)
);
  logic             RX_tick;
  logic             ENABLE;
  logic             START;
  logic             RX_in;
  logic             TICK_EN;
  logic             BIT_DONE;
  logic             SAMPLE_BIT;
  logic [CNT_W-1:0] PHASE;

  modport master (
    output RX_tick, ENABLE, START, RX_in,
    input  TICK_EN, BIT_DONE, SAMPLE_BIT, PHASE
  );

  modport slave (
    input  RX_tick, ENABLE, START, RX_in,
    output TICK_EN, BIT_DONE, SAMPLE_BIT, PHASE
  );
endinterface

// File: rtl/maj3_vote.sv
// Combinational 2-of-3 majority voter for the oversampled line captures.
module maj3_vote (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);

  // Output follows whichever value at least two inputs agree on.
  assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/rx_sample_timer.sv
// Oversampling bit timer for the UART receiver. Counts oversample ticks
// within a bit, pulses TICK_EN at the sample point and BIT_DONE at the last
// tick of the bit, and captures the line into SAMPLE_BIT.
// Optional build macro: RX_MAJORITY_VOTE_EN -- captures the line at three
// consecutive phases around the sample point and reports the 2-of-3 vote,
// with TICK_EN moved to the last of the three ticks.
module rx_sample_timer import uart_pkg::*; #(
  parameter int OVS       = UART_OVS_DEFAULT,
  parameter int SAMPLE_PT = OVS / 2 - 1,
  parameter int CNT_W     = $clog2(OVS)
) (
  input  logic               CLK,
  input  logic               RST,
  rx_sample_timer_if.slave   bus
);

  // Wrap is an explicit compare so non-power-of-2 OVS counts exactly.
  localparam logic [CNT_W-1:0] LAST_PHASE   = CNT_W'(OVS - 1);
`ifdef RX_MAJORITY_VOTE_EN
  localparam logic [CNT_W-1:0] VOTE_A_PHASE = CNT_W'(SAMPLE_PT - 1);
  localparam logic [CNT_W-1:0] VOTE_B_PHASE = CNT_W'(SAMPLE_PT);
  localparam logic [CNT_W-1:0] STROBE_PHASE = CNT_W'(SAMPLE_PT + 1);
`else
  localparam logic [CNT_W-1:0] STROBE_PHASE = CNT_W'(SAMPLE_PT);
`endif

  logic [CNT_W-1:0] phase_reg;
  logic             tick_en_reg;
  logic             bit_done_reg;
  logic             sample_bit_reg;

`ifdef RX_MAJORITY_VOTE_EN
  // The first two captures are held; the third is the live line value on
  // the strobe tick, so the vote lands in the same cycle as TICK_EN.
  logic vote_a_reg;
  logic vote_b_reg;
  logic vote_bit;

  maj3_vote u_vote (
    .a (vote_a_reg),
    .b (vote_b_reg),
    .c (bus.RX_in),
    .y (vote_bit)
  );
`endif

  // Phase counter, strobes and line capture; reset > ENABLE > START > tick.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      phase_reg      <= '0;
      tick_en_reg    <= 1'b0;
      bit_done_reg   <= 1'b0;
      sample_bit_reg <= UART_IDLE_LVL;
`ifdef RX_MAJORITY_VOTE_EN
      vote_a_reg     <= UART_IDLE_LVL;
      vote_b_reg     <= UART_IDLE_LVL;
`endif
    end else if (!bus.ENABLE) begin
      // Held cleared; the last sampled bit is kept for the FSM.
      phase_reg      <= '0;
      tick_en_reg    <= 1'b0;
      bit_done_reg   <= 1'b0;
`ifdef RX_MAJORITY_VOTE_EN
      vote_a_reg     <= UART_IDLE_LVL;
      vote_b_reg     <= UART_IDLE_LVL;
`endif
    end else if (bus.START) begin
      // Realign: a coincident tick is dropped entirely.
      phase_reg      <= '0;
      tick_en_reg    <= 1'b0;
      bit_done_reg   <= 1'b0;
    end else if (bus.RX_tick) begin
      phase_reg      <= (phase_reg == LAST_PHASE) ? '0 : phase_reg + CNT_W'(1);
      tick_en_reg    <= (phase_reg == STROBE_PHASE);
      bit_done_reg   <= (phase_reg == LAST_PHASE);
`ifdef RX_MAJORITY_VOTE_EN
      if (phase_reg == VOTE_A_PHASE) vote_a_reg <= bus.RX_in;
      if (phase_reg == VOTE_B_PHASE) vote_b_reg <= bus.RX_in;
      if (phase_reg == STROBE_PHASE) sample_bit_reg <= vote_bit;
`else
      if (phase_reg == STROBE_PHASE) sample_bit_reg <= bus.RX_in;
`endif
    end else begin
      tick_en_reg    <= 1'b0;
      bit_done_reg   <= 1'b0;
    end
  end

  assign bus.PHASE      = phase_reg;
  assign bus.TICK_EN    = tick_en_reg;
  assign bus.BIT_DONE   = bit_done_reg;
  assign bus.SAMPLE_BIT = sample_bit_reg;

endmodule

// File: doc/rx_sample_timer.md
# rx_sample_timer

Parametrised oversampling bit timer for the UART receiver, successor to the fixed 16x tick counter. It counts baud-rate oversample ticks and emits a one-cycle sample strobe at a programmable point inside each bit, plus an end-of-bit strobe. It also captures the sampled line value, optionally as a 3-sample majority vote. It sits between the baud tick generator and the RX framing FSM, which drives `START` on start-bit detection and `ENABLE` for the frame duration.

## Interface
- `OVS`, 16: oversample ticks per bit; legal range ≥ 4.
- `SAMPLE_PT`, `OVS/2-1`: tick count at which the bit is sampled; legal range 1 … `OVS-2`.
- `CNT_W`, `$clog2(OVS)`: counter width; derived, not overridden.

Ports:
- `CLK` input 1: single clock; all logic on its rising edge.
- `RST` input 1: reset, synchronous, active-low.
- `RX_tick` input 1: one-`CLK` oversample tick from the baud generator.
- `ENABLE` input 1: run gate from the RX FSM; low holds the block cleared.
- `START` input 1: one-cycle realign pulse; forces phase to 0.
- `RX_in` input 1: synchronised serial line.
- `TICK_EN` output 1: one-cycle sample strobe.
- `BIT_DONE` output 1: one-cycle end-of-bit strobe.
- `SAMPLE_BIT` output 1: sampled bit value; valid from `TICK_EN` until the next `TICK_EN`.
- `PHASE` output `CNT_W`: current tick count within the bit.

## Operation
- Reset (`RST`=0 at a `CLK` edge): `PHASE`=0, `TICK_EN`=0, `BIT_DONE`=0, `SAMPLE_BIT`=1 (idle line level), vote registers = 1.
- Priority, highest first: reset, `ENABLE`=0, `START`, `RX_tick`.
- `ENABLE`=0: `PHASE` held at 0, strobes 0, vote registers cleared to 1, `SAMPLE_BIT` holds its value.
- `START`=1 (with `ENABLE`=1): `PHASE` ← 0. A coincident `RX_tick` is discarded: no increment, no strobe.
- `RX_tick`=1 (with `ENABLE`=1 and `START`=0):
  - If `PHASE`=`OVS-1`, `PHASE` ← 0, else `PHASE` ← `PHASE+1`.
  - If `PHASE`=`SAMPLE_PT`, `RX_in` is captured into `SAMPLE_BIT` and `TICK_EN` pulses.
  - If `PHASE`=`OVS-1`, `BIT_DONE` pulses.
- Strobes are 0 in every cycle not listed above and never exceed one `CLK`.
- Counter arithmetic is unsigned `CNT_W`-bit. The wrap is an explicit compare against `OVS-1`, so non-power-of-2 `OVS` (e.g. 10, 13) is exact.
- Gaps between `RX_tick` pulses of any length are tolerated. Back-to-back ticks on consecutive `CLK`s are legal.

## Timing
- `TICK_EN`, `BIT_DONE` and `SAMPLE_BIT` are registered. They appear in the cycle after the `CLK` edge that sampled the qualifying `RX_tick`.
- `PHASE` updates on that same edge.
- Bit period = `OVS` ticks.
- First `TICK_EN` after `START` arrives on tick number `SAMPLE_PT+1`, counting the ticks that follow `START`.
- First `BIT_DONE` after `START` arrives on tick number `OVS`.
- `ENABLE` falling mid-bit: the next cycle shows `PHASE`=0 with no strobes. No pending strobe survives.
- Reset mid-bit behaves identically to `ENABLE` falling, except that `SAMPLE_BIT` returns to 1.

## Configuration
- `RX_MAJORITY_VOTE_EN` defined:
  - `RX_in` is captured on the qualifying ticks at `PHASE` = `SAMPLE_PT-1`, `SAMPLE_PT` and `SAMPLE_PT+1`.
  - `TICK_EN` moves to the tick at `SAMPLE_PT+1`, so it arrives one tick later than in the default build.
  - `SAMPLE_BIT` = 2-of-3 majority of the three captures, updated in the same cycle as `TICK_EN`.
- Undefined (default): single capture at `SAMPLE_PT` as in Operation; no vote registers are synthesised.

## Structure
- Shared `uart_pkg`:
  - `UART_OVS_DEFAULT` = 16.
  - `UART_IDLE_LVL` = 1'b1.
- Sub-module `maj3_vote`: combinational 2-of-3 voter, instantiated only under `RX_MAJORITY_VOTE_EN`.
- All counters and strobe logic stay in `rx_sample_timer`.

## Test plan
- Default parameters, `ENABLE`=1, `START` pulse, then 32 ticks spaced 3 `CLK` apart:
  - `TICK_EN` after ticks 8 and 24.
  - `BIT_DONE` after ticks 16 and 32.
  - `PHASE` wraps 15→0.
- `OVS`=10, `SAMPLE_PT`=4, `RX_in` alternating per bit: `TICK_EN` every 10 ticks, and `SAMPLE_BIT` toggles on each `TICK_EN`.
- `START` coincident with `RX_tick` at `PHASE`=9: `PHASE`=0 the next cycle, with no `TICK_EN` and no `BIT_DONE`.
- `ENABLE` dropped at `PHASE`=5, then re-raised: `PHASE`=0 and no strobes while low; the count resumes from 0.
- `RST` low for 1 cycle at `PHASE`=12 during back-to-back ticks: all outputs return to reset values the next cycle, and `SAMPLE_BIT`=1.
- With `RX_MAJORITY_VOTE_EN` defined, `RX_in` = 1,0,1 at phases 6, 7, 8:
  - `TICK_EN` after tick 9, with `SAMPLE_BIT`=1.
  - With `RX_in` = 0,0,1 instead, `SAMPLE_BIT`=0.
